// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared definitions for the UART LED command parser:
//   - state_t      : parser FSM states
//   - ASCII_*      : byte constants used by the parser and reply generator
//   - is_hex       : 1 when a byte is 0-9, A-F or a-f
//   - hex_to_nib   : ASCII hex digit -> 4-bit value (only meaningful when is_hex)
//   - nib_to_hex   : 4-bit value -> upper-case ASCII hex digit
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_EOL  = 3'd3,
        ST_SKIP = 3'd4,
        ST_RESP = 3'd5,
        ST_EOLQ = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // 'A'/'a' both have low nibble 1, so letters map to low nibble + 9.
    function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
        logic [3:0] low;
        low = c[3:0];
        if (c <= 8'h39) begin
            return low;
        end
        return low + 4'd9;
    endfunction

    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_cmd_resp.sv
// uart_cmd_resp
//   Reply buffer for the command parser. Holds up to three bytes and hands them
//   to the transmitter one at a time.
//
//   Handshake: a byte moves on a rising edge where tx_req && tx_cts. tx_data is
//   stable while tx_req is high; the next byte appears the cycle after each
//   transfer, and tx_req drops the cycle after the last byte transfers.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   load          capture load_len bytes (load_b0..b2) and start sending
//   load_len      number of bytes to send (2 or 3)
//   load_b0..b2   reply bytes, b0 sent first
//   tx_cts        transmitter ready
//   tx_data       byte presented to the transmitter
//   tx_req        tx_data valid
//   done          combinational: the last byte transfers at this edge
module uart_cmd_resp (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] load_len,
    input  logic [7:0] load_b0,
    input  logic [7:0] load_b1,
    input  logic [7:0] load_b2,
    input  logic       tx_cts,
    output logic [7:0] tx_data,
    output logic       tx_req,
    output logic       done
);

    logic [7:0] bytes_q [3];
    logic [1:0] idx_q;
    logic [1:0] len_q;
    logic       last;

    assign last = (idx_q == (len_q - 2'd1));
    assign done = tx_req && tx_cts && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_req     <= 1'b0;
            tx_data    <= 8'h00;
            idx_q      <= 2'd0;
            len_q      <= 2'd0;
            bytes_q[0] <= 8'h00;
            bytes_q[1] <= 8'h00;
            bytes_q[2] <= 8'h00;
        end else if (load) begin
            bytes_q[0] <= load_b0;
            bytes_q[1] <= load_b1;
            bytes_q[2] <= load_b2;
            idx_q      <= 2'd0;
            len_q      <= load_len;
            tx_req     <= 1'b1;
            tx_data    <= load_b0;
        end else if (tx_req && tx_cts) begin
            if (last) begin
                // tx_data keeps the final byte; only tx_req matters from here.
                tx_req <= 1'b0;
            end else begin
                idx_q   <= idx_q + 2'd1;
                tx_data <= bytes_q[idx_q + 2'd1];
            end
        end
    end

endmodule

// File: rtl/uart_led_cmd.sv
// uart_led_cmd
//   Line-oriented command parser sitting between uart_rx and uart_tx.
//   "L<hex><hex>\n" sets the LED register and replies "K\n"; any malformed line
//   replies "E\n"; a bare "\n" is silently ignored. '\r' is ignored everywhere.
//   A partial line left idle for TIMEOUT_CYCLES clocks is dropped without reply
//   (TIMEOUT_CYCLES = 0 disables the timeout).
//
//   Optional feature, macro UART_LED_CMD_READBACK_EN: "?\n" replies with the
//   LED value as two upper-case hex digits and '\n'. Without the macro '?' is
//   an ordinary invalid byte.
//
// Parameters
//   LED_RESET       leds value after reset
//   TIMEOUT_CYCLES  idle clocks before a partial line is dropped; 0 = never
//
// Ports
//   clk       sole clock
//   rst       synchronous active-high reset
//   in_data   received byte, valid with in_valid
//   in_valid  one-cycle strobe per received byte, no backpressure
//   tx_data   reply byte to the transmitter
//   tx_req    tx_data valid; transfer on tx_req && tx_cts
//   tx_cts    transmitter ready
//   leds      LED register
//   busy      reply in progress (state RESP)
//   overrun   sticky: a byte arrived while busy and was dropped
module uart_led_cmd
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] LED_RESET      = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_cts,
    output logic [7:0] leds,
    output logic       busy,
    output logic       overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES < 1) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic       byte_ok;     // non-CR byte present this cycle
    logic       accept;      // byte_ok and the parser is not replying
    logic       timeout_hit;
    logic       resp_done;

    logic       load;
    logic [1:0] load_len;
    logic [7:0] load_b0, load_b1, load_b2;
    logic       hi_en, lo_en, leds_en;

    assign byte_ok = in_valid && (in_data != ASCII_CR);
    assign accept  = byte_ok && (state_q != ST_RESP);
    assign busy    = (state_q == ST_RESP);

    // Only partial-line states can time out; IDLE and RESP hold the counter at 0.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) &&
                         (state_q != ST_IDLE) && (state_q != ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_len = 2'd2;
        load_b0  = ASCII_E;
        load_b1  = ASCII_LF;
        load_b2  = ASCII_LF;
        hi_en    = 1'b0;
        lo_en    = 1'b0;
        leds_en  = 1'b0;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == ASCII_L) begin
                        state_d = ST_HI;
                    end else if (in_data == ASCII_LF) begin
                        state_d = ST_IDLE;
`ifdef UART_LED_CMD_READBACK_EN
                    end else if (in_data == ASCII_Q) begin
                        state_d = ST_EOLQ;
`endif
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_HI: begin
                    if (is_hex(in_data)) begin
                        hi_en   = 1'b1;
                        state_d = ST_LO;
                    end else if (in_data == ASCII_LF) begin
                        load    = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_LO: begin
                    if (is_hex(in_data)) begin
                        lo_en   = 1'b1;
                        state_d = ST_EOL;
                    end else if (in_data == ASCII_LF) begin
                        load    = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_EOL: begin
                    if (in_data == ASCII_LF) begin
                        leds_en = 1'b1;
                        load    = 1'b1;
                        load_b0 = ASCII_K;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
`ifdef UART_LED_CMD_READBACK_EN
                ST_EOLQ: begin
                    if (in_data == ASCII_LF) begin
                        load     = 1'b1;
                        load_len = 2'd3;
                        load_b0  = nib_to_hex(leds[7:4]);
                        load_b1  = nib_to_hex(leds[3:0]);
                        load_b2  = ASCII_LF;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
`endif
                ST_SKIP: begin
                    if (in_data == ASCII_LF) begin
                        load    = 1'b1;
                        state_d = ST_RESP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q == ST_RESP) && resp_done) begin
            state_d = ST_IDLE;
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds    <= LED_RESET;
            hi_q    <= 4'h0;
            lo_q    <= 4'h0;
            overrun <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (hi_en) begin
                hi_q <= hex_to_nib(in_data);
            end
            if (lo_en) begin
                lo_q <= hex_to_nib(in_data);
            end
            if (leds_en) begin
                leds <= {hi_q, lo_q};
            end
            // Includes the edge where the final reply byte transfers.
            if (byte_ok && busy) begin
                overrun <= 1'b1;
            end
            if (accept || timeout_hit || (state_q == ST_IDLE) || (state_q == ST_RESP)) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    uart_cmd_resp u_resp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_len (load_len),
        .load_b0  (load_b0),
        .load_b1  (load_b1),
        .load_b2  (load_b2),
        .tx_cts   (tx_cts),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .done     (resp_done)
    );

endmodule

// File: tb/tb_uart_led_cmd.sv
// tb_uart_led_cmd
//   Directed bench for uart_led_cmd (TIMEOUT_CYCLES=16). Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_led_cmd;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_cts;
    logic [7:0] leds;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_led_cmd #(
        .LED_RESET      (8'h00),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .tx_cts   (tx_cts),
        .leds     (leds),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_byte(LF);
    endtask

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back(a);
        exp_q.push_back(b);
    endtask

    // Pops expected bytes and compares each against a transferred byte.
    task automatic drain_reply(input string tag);
        logic [7:0] e;
        bit         seen;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            seen = 1'b0;
            for (int w = 0; w < 100; w++) begin
                if (tx_req === 1'b1 && tx_cts === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!seen) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                exp_q.delete();
                return;
            end
            check(tag, {24'h0, tx_data}, {24'h0, e});
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tx_cts   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_leds",    {24'h0, leds},    32'h00);
        check("rst_tx_req",  {31'h0, tx_req},  32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h00);
        check("rst_busy",    {31'h0, busy},    32'd0);
        check("rst_overrun", {31'h0, overrun}, 32'd0);

        // Good command.
        send_line("L5A");
        check("l5a_leds",    {24'h0, leds},   32'h5A);
        check("l5a_busy",    {31'h0, busy},   32'd1);
        check("l5a_tx_req",  {31'h0, tx_req}, 32'd1);
        push2(8'h4B, LF);
        drain_reply("l5a_reply");
        check("l5a_req_drop",  {31'h0, tx_req}, 32'd0);
        check("l5a_busy_drop", {31'h0, busy},   32'd0);

        // Bad hex digit.
        send_line("Lq3");
        check("lq3_leds", {24'h0, leds}, 32'h5A);
        push2(8'h45, LF);
        drain_reply("lq3_reply");

        // Bare newline: no reply.
        send_byte(LF);
        check("bare_lf_req", {31'h0, tx_req}, 32'd0);
        repeat (3) @(negedge clk);
        check("bare_lf_req_later", {31'h0, tx_req}, 32'd0);

        // CRs ignored; transmitter stalls for 20 cycles.
        tx_cts = 1'b0;
        send_str("L");
        send_byte(CR);
        send_str("7f");
        send_byte(CR);
        send_byte(LF);
        check("cr_leds", {24'h0, leds}, 32'h7F);
        bad = 0;
        repeat (20) begin
            if (!(tx_req === 1'b1 && tx_data === 8'h4B)) bad++;
            @(negedge clk);
        end
        check("cts_hold_stable", bad, 0);
        tx_cts = 1'b1;
        push2(8'h4B, LF);
        drain_reply("cr_reply");

        // Byte during reply is dropped and flagged.
        tx_cts = 1'b0;
        send_line("L12");
        check("ovr_before", {31'h0, overrun}, 32'd0);
        send_byte(8'h4C);
        check("ovr_set", {31'h0, overrun}, 32'd1);
        tx_cts = 1'b1;
        push2(8'h4B, LF);
        drain_reply("ovr_reply");
        check("ovr_leds", {24'h0, leds}, 32'h12);
        send_line("L01");
        check("after_ovr_leds", {24'h0, leds}, 32'h01);
        push2(8'h4B, LF);
        drain_reply("after_ovr_reply");
        check("ovr_sticky", {31'h0, overrun}, 32'd1);

        // Reset in the middle of a reply.
        tx_cts = 1'b0;
        send_line("L99");
        check("midrst_req_before", {31'h0, tx_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_req",     {31'h0, tx_req},  32'd0);
        check("midrst_busy",    {31'h0, busy},    32'd0);
        check("midrst_leds",    {24'h0, leds},    32'h00);
        check("midrst_overrun", {31'h0, overrun}, 32'd0);
        tx_cts = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_resume", {31'h0, tx_req}, 32'd0);

        // Byte arriving on the edge the final reply byte transfers.
        send_line("L22");
        check("edge_first", {24'h0, tx_data}, 32'h4B);
        @(negedge clk);
        check("edge_second", {24'h0, tx_data}, {24'h0, LF});
        in_data  = 8'h4C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("edge_overrun", {31'h0, overrun}, 32'd1);
        check("edge_req",     {31'h0, tx_req},  32'd0);
        check("edge_busy",    {31'h0, busy},    32'd0);
        // Had the 'L' been taken, this LF would produce an error reply.
        send_byte(LF);
        check("edge_dropped", {31'h0, tx_req}, 32'd0);
        check("edge_leds", {24'h0, leds}, 32'h22);

        // Timeout: 16 idle cycles drop the partial line.
        send_str("L3");
        repeat (16) @(negedge clk);
        send_line("4");
        check("to_leds", {24'h0, leds}, 32'h22);
        push2(8'h45, LF);
        drain_reply("to_reply");

        // 14 idle cycles stay inside the window.
        send_str("L3");
        repeat (14) @(negedge clk);
        send_line("4");
        check("no_to_leds", {24'h0, leds}, 32'h34);
        push2(8'h4B, LF);
        drain_reply("no_to_reply");

        // Readback query.
        send_line("LC3");
        push2(8'h4B, LF);
        drain_reply("lc3_reply");
        send_line("?");
`ifdef UART_LED_CMD_READBACK_EN
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h33);
        exp_q.push_back(LF);
`else
        push2(8'h45, LF);
`endif
        drain_reply("query_reply");
        check("query_leds", {24'h0, leds}, 32'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
